// File: rtl/sar_adc_spi_rx.sv
// Multi-channel SAR ADC capture controller: shared CONVST/SCLK to NUM_CH ADCs,
// one SDO per ADC, single-shot or free-running conversion with parallel word capture.
module sar_adc_spi_rx #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int HALF_DIV = 4,
  parameter int CONV_CYC = 160,
  parameter int PER_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont_en,
  input  logic [PER_W-1:0]         period,
  input  logic                     clr_ovr,
  input  logic [NUM_CH-1:0]        sdo,
  output logic                     convst,
  output logic                     sclk,
  output logic                     din,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     data_valid,
  output logic                     overrun
);

  localparam int RD_CYC  = 2 * HALF_DIV * DATA_W;
  localparam int MIN_PER = CONV_CYC + RD_CYC + 2;
  localparam int PMIN_W  = $clog2(MIN_PER + 1);
  localparam int PW      = (PER_W > PMIN_W) ? PER_W : PMIN_W;
  localparam int CW      = $clog2(CONV_CYC + 1);
  localparam int HW      = $clog2(HALF_DIV + 1);
  localparam int BW      = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_READ,
    S_DONE,
    S_WAIT
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  conv_cnt_q, conv_cnt_d;
  logic [HW-1:0]                  half_cnt_q, half_cnt_d;
  logic [BW-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]                  per_cnt_q, per_cnt_d;
  logic [PW-1:0]                  eff_q, eff_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  shreg_q, shreg_d;
  logic                           convst_q, convst_d;
  logic                           sclk_q, sclk_d;
  logic                           busy_q, busy_d;
  logic [NUM_CH*DATA_W-1:0]       dout_q, dout_d;
  logic                           valid_q, valid_d;
  logic                           ovr_q, ovr_d;
  logic                           enter_conv;

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    eff_d      = eff_q;
    shreg_d    = shreg_q;
    convst_d   = convst_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ovr_d      = ovr_q;
    enter_conv = 1'b0;
    // Period counter runs from every CONV entry and saturates instead of wrapping.
    per_cnt_d  = (per_cnt_q != '1) ? per_cnt_q + PW'(1) : per_cnt_q;

    if (start && (busy_q || state_q == S_WAIT)) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          enter_conv = 1'b1;
        end
      end
      S_CONV: begin
        if (conv_cnt_q == CW'(CONV_CYC - 1)) begin
          state_d    = S_READ;
          convst_d   = 1'b0;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
        end
      end
      S_READ: begin
        if (half_cnt_q == HW'(HALF_DIV - 1)) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          // Sample on the edge that raises SCLK; leave after the last high phase.
          if (!sclk_q) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
              shreg_d[ch] = {shreg_q[ch][DATA_W-2:0], sdo[ch]};
            end
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (bit_cnt_q == BW'(DATA_W)) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            dout_d  = shreg_q;
          end
        end else begin
          half_cnt_d = half_cnt_q + HW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = cont_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!cont_en) begin
          state_d = S_IDLE;
        end else if (per_cnt_q >= eff_q - PW'(1)) begin
          enter_conv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_conv) begin
      state_d    = S_CONV;
      convst_d   = 1'b1;
      busy_d     = 1'b1;
      conv_cnt_d = '0;
      per_cnt_d  = '0;
      shreg_d    = '0;
      eff_d      = (PW'(period) > PW'(MIN_PER)) ? PW'(period) : PW'(MIN_PER);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      per_cnt_q  <= '0;
      eff_q      <= '0;
      shreg_q    <= '0;
      convst_q   <= 1'b0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      per_cnt_q  <= per_cnt_d;
      eff_q      <= eff_d;
      shreg_q    <= shreg_d;
      convst_q   <= convst_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign convst     = convst_q;
  assign sclk       = sclk_q;
  assign din        = 1'b1;
  assign busy       = busy_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_adc_spi_rx.sv
// Bench for sar_adc_spi_rx: frame-time reference model with per-cycle compare,
// behavioural ADC models on each SDO, and a parameter sweep on two extra instances.
module tb_sar_adc_spi_rx;

  localparam int CC     = 160;
  localparam int RL_A   = 2 * 4 * 16;
  localparam int DONE_A = CC + RL_A;
  localparam int MIN_A  = DONE_A + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // instance A: defaults
  logic             start_a = 1'b0, cont_a = 1'b0, clr_a = 1'b0;
  logic [15:0]      period_a = '0;
  logic [1:0]       sdo_a;
  logic             convst_a, sclk_a, din_a, busy_a, data_valid_a, overrun_a;
  logic [31:0]      data_out_a;

  // instances B (1ch/18b/H2) and C (8ch/16b)
  logic             start_s = 1'b0;
  logic [0:0]       sdo_b;
  logic [7:0]       sdo_c;
  logic             convst_b, sclk_b, din_b, busy_b, data_valid_b, overrun_b;
  logic             convst_c, sclk_c, din_c, busy_c, data_valid_c, overrun_c;
  logic [17:0]      data_out_b;
  logic [127:0]     data_out_c;

  always #5 clk = ~clk;

  sar_adc_spi_rx u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont_en(cont_a), .period(period_a),
    .clr_ovr(clr_a), .sdo(sdo_a), .convst(convst_a), .sclk(sclk_a), .din(din_a),
    .busy(busy_a), .data_out(data_out_a), .data_valid(data_valid_a), .overrun(overrun_a)
  );

  sar_adc_spi_rx #(.DATA_W(18), .NUM_CH(1), .HALF_DIV(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_s), .cont_en(1'b0), .period(16'd0),
    .clr_ovr(1'b0), .sdo(sdo_b), .convst(convst_b), .sclk(sclk_b), .din(din_b),
    .busy(busy_b), .data_out(data_out_b), .data_valid(data_valid_b), .overrun(overrun_b)
  );

  sar_adc_spi_rx #(.DATA_W(16), .NUM_CH(8)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_s), .cont_en(1'b0), .period(16'd0),
    .clr_ovr(1'b0), .sdo(sdo_c), .convst(convst_c), .sclk(sclk_c), .din(din_c),
    .busy(busy_c), .data_out(data_out_c), .data_valid(data_valid_c), .overrun(overrun_c)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC models: word latched when CONVST rises, MSB presented first, next bit after each SCLK fall
  logic [1:0][15:0] nw_a = '0, cw_a = '0;
  logic [17:0]      nw_b = '0, cw_b = '0;
  logic [7:0][15:0] nw_c = '0, cw_c = '0;
  int bi_a = 0, bi_b = 0, bi_c = 0;

  always @(posedge convst_a) begin cw_a = nw_a; bi_a = 0; end
  always @(negedge sclk_a) bi_a = bi_a + 1;
  always @(posedge convst_b) begin cw_b = nw_b; bi_b = 0; end
  always @(negedge sclk_b) bi_b = bi_b + 1;
  always @(posedge convst_c) begin cw_c = nw_c; bi_c = 0; end
  always @(negedge sclk_c) bi_c = bi_c + 1;

  always_comb begin
    sdo_a = '0;
    for (int c = 0; c < 2; c++) if (bi_a < 16) sdo_a[c] = cw_a[c][15 - bi_a];
  end
  always_comb begin
    sdo_b = '0;
    if (bi_b < 18) sdo_b[0] = cw_b[17 - bi_b];
  end
  always_comb begin
    sdo_c = '0;
    for (int c = 0; c < 8; c++) if (bi_c < 16) sdo_c[c] = cw_c[c][15 - bi_c];
  end

  // Reference model for A: m_ft is the cycle index since the last conversion start
  bit          m_act = 1'b0, m_wait = 1'b0, m_ovr = 1'b0;
  int          m_ft = 0, m_eff = 0;
  logic [31:0] m_w = '0, m_dout = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_wait = 1'b0; m_ovr = 1'b0; m_ft = 0; m_dout = '0;
    end else begin
      if (start_a && (m_act || m_wait)) m_ovr = 1'b1;
      else if (clr_a) m_ovr = 1'b0;
      if (m_act) begin
        if (m_ft == DONE_A) begin
          m_act = 1'b0; m_wait = cont_a; m_ft++;
        end else begin
          m_ft++;
          if (m_ft == DONE_A) m_dout = m_w;
        end
      end else if (m_wait) begin
        if (!cont_a) m_wait = 1'b0;
        else if (m_ft + 1 == m_eff) begin
          m_wait = 1'b0; m_act = 1'b1; m_ft = 0; m_w = nw_a;
          m_eff = (int'(period_a) > MIN_A) ? int'(period_a) : MIN_A;
        end else m_ft++;
      end else if (start_a) begin
        m_act = 1'b1; m_ft = 0; m_w = nw_a;
        m_eff = (int'(period_a) > MIN_A) ? int'(period_a) : MIN_A;
      end
    end
  end

  always @(negedge clk) begin
    chk("convst", 128'(convst_a), 128'(m_act && m_ft < CC));
    chk("sclk", 128'(sclk_a),
        128'(m_act && m_ft >= CC && m_ft < DONE_A && (((m_ft - CC) / 4) % 2 == 1)));
    chk("busy", 128'(busy_a), 128'(m_act));
    chk("data_valid", 128'(data_valid_a), 128'(m_act && m_ft == DONE_A));
    chk("data_out", 128'(data_out_a), 128'(m_dout));
    chk("overrun", 128'(overrun_a), 128'(m_ovr));
    chk("din", 128'(din_a), 128'(1'b1));
  end

  // CONVST rise monitor for period measurements
  int  cyc = 0, cv_n = 0, cv_last = 0, cv_prev = 0;
  logic cv_d = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (convst_a && !cv_d) begin cv_prev = cv_last; cv_last = cyc; cv_n++; end
    cv_d = convst_a;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_a();
    tick(); start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    for (int t = 1; t <= budget; t++) begin
      if (data_valid_a) begin lat = t; break; end
      tick();
    end
  endtask

  task automatic wait_sclk(input int budget, output int found);
    found = 0;
    for (int t = 0; t < budget; t++) begin
      if (sclk_a) begin found = 1; break; end
      tick();
    end
  endtask

  int lat, ccnt, rises, first_r, last_r, badsp, bsy_bad, found, n0, n1, nv, k, lat_b, lat_c;
  logic sclk_prev;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_convst", 128'(convst_a), 128'(0));
    chk("rst_sclk", 128'(sclk_a), 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_dout", 128'(data_out_a), 128'(0));
    rst = 1'b0;
    tick();

    // single frame with fixed words, plus SCLK/CONVST timing
    nw_a = {16'h1234, 16'hA5C3};
    pulse_a();
    lat = 0; ccnt = 0; rises = 0; first_r = 0; last_r = 0; badsp = 0; bsy_bad = 0;
    sclk_prev = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      if (convst_a) ccnt++;
      if (sclk_a && !sclk_prev) begin
        if (rises == 0) first_r = t;
        else if (t - last_r != 8) badsp++;
        last_r = t; rises++;
      end
      sclk_prev = sclk_a;
      if (!busy_a) bsy_bad++;
      if (data_valid_a) begin lat = t; break; end
      tick();
    end
    chk_int("t1_latency", lat, 289);
    chk("t1_data", 128'(data_out_a), 128'(32'h1234A5C3));
    chk_int("t2_convst_len", ccnt, 160);
    chk_int("t2_sclk_rises", rises, 16);
    chk_int("t2_first_rise", first_r, 165);
    chk_int("t2_rise_spacing", badsp, 0);
    chk_int("t1_busy_high", bsy_bad, 0);
    tick();
    chk("t1_busy_low", 128'(busy_a), 128'(0));
    chk("t1_hold", 128'(data_out_a), 128'(32'h1234A5C3));

    // continuous mode, period 400, drop cont_en mid-READ
    period_a = 16'd400; cont_a = 1'b1; n0 = cv_n;
    pulse_a();
    for (int t = 0; t < 1500 && cv_n < n0 + 3; t++) tick();
    chk_int("t3_rises400", cv_n - n0, 3);
    chk_int("t3_period400", cv_last - cv_prev, 400);
    wait_sclk(400, found);
    chk_int("t3_in_read", found, 1);
    cont_a = 1'b0;
    wait_valid(400, lat);
    chk_int("t3_drop_valid", int'(lat != 0), 1);
    n1 = cv_n;
    repeat (900) tick();
    chk_int("t3_no_more_convst", cv_n - n1, 0);

    // continuous mode, period below minimum gets clamped
    period_a = 16'd100; cont_a = 1'b1; n0 = cv_n;
    pulse_a();
    for (int t = 0; t < 1500 && cv_n < n0 + 3; t++) tick();
    chk_int("t3_rises100", cv_n - n0, 3);
    chk_int("t3_period_clamp", cv_last - cv_prev, 290);
    cont_a = 1'b0;
    repeat (400) tick();

    // overrun: start at cycle 50 of a frame
    nw_a = {16'h0F1E, 16'h2D3C};
    pulse_a();
    repeat (49) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid(400, lat);
    chk_int("t4_latency", lat, 239);
    chk("t4_data", 128'(data_out_a), 128'(32'h0F1E2D3C));
    chk("t4_ovr_set", 128'(overrun_a), 128'(1));
    repeat (3) tick();
    pulse_a();
    repeat (20) tick();
    clr_a = 1'b1; start_a = 1'b1; tick(); clr_a = 1'b0; start_a = 1'b0;
    chk("t4_set_wins", 128'(overrun_a), 128'(1));
    wait_valid(400, lat);
    repeat (2) tick();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    chk("t4_clr", 128'(overrun_a), 128'(0));

    // reset mid-READ
    nw_a = {16'h5555, 16'hAAAA};
    pulse_a();
    wait_sclk(400, found);
    chk_int("t5_in_read", found, 1);
    rst = 1'b1; tick();
    chk("t5_convst", 128'(convst_a), 128'(0));
    chk("t5_sclk", 128'(sclk_a), 128'(0));
    chk("t5_dout", 128'(data_out_a), 128'(0));
    chk("t5_valid", 128'(data_valid_a), 128'(0));
    rst = 1'b0;
    nv = 0;
    repeat (400) begin tick(); if (data_valid_a) nv++; end
    chk_int("t5_no_valid", nv, 0);
    nw_a = {16'h0F0F, 16'hBEEF};
    pulse_a();
    wait_valid(400, lat);
    chk_int("t5_latency", lat, 289);
    chk("t5_data", 128'(data_out_a), 128'(32'h0F0FBEEF));
    repeat (3) tick();

    // randomized frames: random words, period, mode and a stray start/clr mid-frame
    for (int f = 0; f < 6; f++) begin
      nw_a = {16'($urandom), 16'($urandom)};
      period_a = 16'($urandom_range(0, 700));
      cont_a = f[0];
      pulse_a();
      k = $urandom_range(5, 250);
      repeat (k) tick();
      if ($urandom_range(0, 1) == 1) start_a = 1'b1; else clr_a = 1'b1;
      tick(); start_a = 1'b0; clr_a = 1'b0;
      wait_valid(400, lat);
      chk_int("rnd_found", int'(lat != 0), 1);
      chk("rnd_data", 128'(data_out_a), 128'(nw_a));
      cont_a = 1'b0;
      repeat (5) tick();
    end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    repeat (300) tick();

    // parameter sweep instances
    for (int f = 0; f < 4; f++) begin
      nw_b = 18'($urandom);
      for (int c = 0; c < 8; c++) nw_c[c] = 16'($urandom);
      tick(); start_s = 1'b1; tick(); start_s = 1'b0;
      lat_b = 0; lat_c = 0;
      for (int t = 1; t <= 400; t++) begin
        if (data_valid_b && lat_b == 0) begin
          lat_b = t;
          chk("sweep_b_data", 128'(data_out_b), 128'(nw_b));
        end
        if (data_valid_c && lat_c == 0) begin
          lat_c = t;
          chk("sweep_c_data", data_out_c, 128'(nw_c));
        end
        tick();
      end
      chk_int("sweep_b_latency", lat_b, 1 + 160 + 2 * 2 * 18);
      chk_int("sweep_c_latency", lat_c, 1 + 160 + 2 * 4 * 16);
      chk("sweep_b_din", 128'(din_b), 128'(1));
      chk("sweep_c_busy", 128'(busy_c), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
